// File: rtl/load_pkg.sv
// Shared definitions for the load alignment unit: RV32 load encodings,
// controller states and the word-crossing rule.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    LAST  = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

  // A load crosses when its last byte falls into the next word.
  function automatic logic crosses(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_LH, F3_LHU: crosses = (offset == 2'b11);
      F3_LW:         crosses = (offset != 2'b00);
      default:       crosses = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte selection and zero/sign extension of a load result taken from a
// little-endian window of up to seven bytes starting at the low word.
module load_extend
  import load_pkg::*;
(
  input  logic [55:0] dword,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sel_s;

  // Shift the addressed byte down to bit 0, then size and extend it.
  always_comb begin
    sel_s = dword[{1'b0, offset, 3'b000} +: 32];
    case (funct3)
      F3_LB:   data = {{24{sel_s[7]}}, sel_s[7:0]};
      F3_LH:   data = {{16{sel_s[15]}}, sel_s[15:0]};
      F3_LW:   data = sel_s;
      F3_LBU:  data = {24'h000000, sel_s[7:0]};
      F3_LHU:  data = {16'h0000, sel_s[15:0]};
      default: data = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// RV32 load alignment unit: turns a byte-addressed load into one or two
// word reads and returns the aligned, extended result with a valid/ready handshake.
module load_align_unit
  import load_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  state_t              state_r;
  logic                req_ready_r;
  logic                mem_rd_en_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_err_r;
  logic [1:0]          offset_r;
  logic [2:0]          funct3_r;
  logic                split_r;
  logic [DATA_W-1:0]   lo_word_r;
  logic [55:0]         dword_s;
  logic [31:0]         ext_data_s;
  logic                cross_s;
  logic                reject_s;

  assign cross_s  = crosses(req_funct3, req_addr[1:0]);
  assign reject_s = !is_legal(req_funct3) || (cross_s && !ALLOW_SPLIT);

  // Only the low three bytes of the high word can ever be selected.
  assign dword_s = split_r ? {mem_rdata[23:0], lo_word_r} : {24'h000000, mem_rdata};

  load_extend u_extend (
    .dword  (dword_s),
    .offset (offset_r),
    .funct3 (funct3_r),
    .data   (ext_data_s)
  );

  // Controller with registered handshake, memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      mem_rd_en_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      resp_err_r   <= 1'b0;
      offset_r     <= 2'b00;
      funct3_r     <= 3'b000;
      split_r      <= 1'b0;
      lo_word_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            offset_r    <= req_addr[1:0];
            funct3_r    <= req_funct3;
            req_ready_r <= 1'b0;
            if (reject_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_data_r  <= {DATA_W{1'b0}};
              split_r      <= 1'b0;
            end else begin
              state_r     <= RD_LO;
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
              split_r     <= cross_s;
            end
          end
        end
        RD_LO: begin
          if (split_r) begin
            state_r    <= RD_HI;
            mem_addr_r <= mem_addr_r + {{(ADDR_W-3){1'b0}}, 3'b100};
          end else begin
            state_r     <= LAST;
            mem_rd_en_r <= 1'b0;
          end
        end
        RD_HI: begin
          lo_word_r   <= mem_rdata;
          mem_rd_en_r <= 1'b0;
          state_r     <= LAST;
        end
        LAST: begin
          resp_data_r  <= ext_data_s;
          resp_err_r   <= 1'b0;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          mem_rd_en_r  <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign mem_rd_en  = mem_rd_en_r;
  assign mem_addr   = mem_addr_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: one split-enabled and one split-disabled instance,
// byte-level memory model and reference loads computed from the load rules.
module tb_load_align_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        resp_ready;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        mem_rd_en  [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_rdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_data  [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_b [logic [31:0]];
  logic [31:0] rd_q [$];

  load_align_unit #(.ADDR_W(32), .DATA_W(32), .ALLOW_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en[0]),
    .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready), .resp_data(resp_data[0]), .resp_err(resp_err[0])
  );

  load_align_unit #(.ADDR_W(32), .DATA_W(32), .ALLOW_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en[1]),
    .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready), .resp_data(resp_data[1]), .resp_err(resp_err[1])
  );

  function automatic logic [7:0] gb(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] get_word(input logic [31:0] w);
    return {gb(w + 32'd3), gb(w + 32'd2), gb(w + 32'd1), gb(w)};
  endfunction

  function automatic void put_word(input logic [31:0] w, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem_b[w + i] = d[8*i +: 8];
  endfunction

  // Memory: one-cycle read latency, garbage when no read was issued.
  always @(posedge clk) begin
    if (mem_rd_en[0] === 1'b1) rd_q.push_back(mem_addr[0]);
    if (mem_rd_en[1] === 1'b1) rd_q.push_back(mem_addr[1]);
    for (int k = 0; k < 2; k++)
      mem_rdata[k] <= (mem_rd_en[k] === 1'b1) ? get_word(mem_addr[k]) : 32'hDEADBEEF;
  end

  // Reference model: byte size, legality, crossing and extended value.
  function automatic int ld_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ld_legal(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit ld_cross(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) + ld_size(f3)) > 4;
  endfunction

  function automatic logic [31:0] ld_value(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int          n;
    n = ld_size(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | ({24'h0, gb(a + i)} << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic run_load(input int u, input logic [31:0] addr, input logic [2:0] f3,
                          input int hold, input string tag);
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    logic [31:0] exp_rd [$];
    int          lat;
    bit          rd_bad;
    exp_err  = !ld_legal(f3) || (u == 1 && ld_cross(addr, f3));
    exp_data = exp_err ? 32'h0 : ld_value(addr, f3);
    exp_lat  = exp_err ? 0 : (ld_cross(addr, f3) ? 3 : 2);
    if (!exp_err) begin
      exp_rd.push_back({addr[31:2], 2'b00});
      if (ld_cross(addr, f3)) exp_rd.push_back({addr[31:2], 2'b00} + 32'd4);
    end
    @(negedge clk);
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b exp 1", tag, req_ready[u]);
    end
    req_addr = addr; req_funct3 = f3; req_valid[u] = 1'b1;
    rd_q.delete();
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    lat = 0;
    while (resp_valid[u] !== 1'b1 && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d exp %0d", tag, lat, exp_lat);
    end
    checks++;
    if (resp_data[u] !== exp_data || resp_err[u] !== exp_err) begin
      errors++;
      $display("FAIL %s result: got data %h err %b exp data %h err %b",
               tag, resp_data[u], resp_err[u], exp_data, exp_err);
    end
    checks++;
    if (req_ready[u] !== 1'b0 || mem_rd_en[u] !== 1'b0) begin
      errors++; $display("FAIL %s resp_state: got ready %b rd_en %b exp 0 0",
                         tag, req_ready[u], mem_rd_en[u]);
    end
    rd_bad = (rd_q.size() != exp_rd.size());
    for (int i = 0; i < rd_q.size() && !rd_bad; i++) rd_bad = (rd_q[i] !== exp_rd[i]);
    checks++;
    if (rd_bad) begin
      errors++; $display("FAIL %s reads: got %0d reads (first %h) exp %0d reads (first %h)",
                         tag, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0,
                         exp_rd.size(), (exp_rd.size() > 0) ? exp_rd[0] : 32'h0);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid[u] !== 1'b1 || resp_data[u] !== exp_data || req_ready[u] !== 1'b0) begin
        errors++; $display("FAIL %s stall: got valid %b data %h ready %b exp 1 %h 0",
                           tag, resp_valid[u], resp_data[u], req_ready[u], exp_data);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      errors++; $display("FAIL %s release: got valid %b ready %b exp 0 1",
                         tag, resp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1 || mem_rd_en[u] !== 1'b0 || mem_addr[u] !== 32'h0 ||
          resp_valid[u] !== 1'b0 || resp_data[u] !== 32'h0 || resp_err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d: got ready %b rd %b addr %h valid %b data %h err %b exp 1 0 0 0 0 0",
                 u, req_ready[u], mem_rd_en[u], mem_addr[u], resp_valid[u], resp_data[u], resp_err[u]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_load(0, 32'h101, 3'b000, 0, "lb_101");
    run_load(0, 32'h102, 3'b101, 0, "lhu_102");
    run_load(0, 32'h102, 3'b001, 0, "lh_102");
    run_load(0, 32'h103, 3'b010, 0, "lw_103");
    run_load(0, 32'h103, 3'b001, 0, "lh_103");
    run_load(0, 32'h100, 3'b010, 0, "lw_100");
  endtask

  task automatic test_stall();
    run_load(0, 32'h101, 3'b100, 3, "stall_lbu");
    run_load(0, 32'h105, 3'b010, 3, "stall_lw_split");
  endtask

  task automatic test_errors();
    run_load(0, 32'h100, 3'b011, 2, "illegal_011");
    run_load(0, 32'h101, 3'b111, 0, "illegal_111");
    run_load(1, 32'h102, 3'b010, 0, "nosplit_lw_102");
    run_load(1, 32'h103, 3'b101, 0, "nosplit_lhu_103");
    run_load(1, 32'h100, 3'b010, 0, "nosplit_lw_100");
    run_load(1, 32'h102, 3'b001, 0, "nosplit_lh_102");
  endtask

  task automatic test_wrap();
    run_load(0, 32'hFFFFFFFE, 3'b010, 0, "wrap_lw");
    run_load(0, 32'hFFFFFFFF, 3'b001, 0, "wrap_lh");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_load(0, 32'h100 + i, 3'b010, 0, $sformatf("b2b_%0d", i));
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'h100 + $urandom_range(0, 7);
        1:       a = 32'h200 + $urandom_range(0, 60);
        default: a = 32'hFFFFFFF8 + $urandom_range(0, 7);
      endcase
      run_load($urandom_range(0, 1), a, 3'($urandom_range(0, 7)), $urandom_range(0, 2),
               $sformatf("rand_%0d", i));
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_addr = 32'h103; req_funct3 = 3'b010; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_rd_en[0] !== 1'b1 || mem_addr[0] !== 32'h104) begin
      errors++; $display("FAIL abort_rd_hi: got rd %b addr %h exp 1 00000104", mem_rd_en[0], mem_addr[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_rd_en[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL abort_drop: got rd %b valid %b ready %b exp 0 0 1",
                         mem_rd_en[0], resp_valid[0], req_ready[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid[0] !== 1'b0 || mem_rd_en[0] !== 1'b0) begin
        errors++; $display("FAIL abort_quiet: got valid %b rd %b exp 0 0", resp_valid[0], mem_rd_en[0]);
      end
    end
    run_load(0, 32'h100, 3'b100, 0, "after_reset_lbu");
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_funct3 = 3'b000;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    put_word(32'h100, 32'h8899AABB);
    put_word(32'h104, 32'h11223344);
    for (int i = 0; i < 17; i++) put_word(32'h200 + 4 * i, $urandom);
    put_word(32'hFFFFFFF8, $urandom);
    put_word(32'hFFFFFFFC, 32'hC3D4E5F6);
    put_word(32'h0, 32'h8A7B6C5D);
    put_word(32'h4, $urandom);
    test_reset();
    test_directed();
    test_stall();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter DATA_W, default 32: word width; only 32 is supported.
REQ-003 Parameter ALLOW_SPLIT, default 1: 1 = word-crossing loads are split into two reads; 0 = word-crossing loads return an error.
REQ-004 clk  in  1  single clock; all flops rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  load request present.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_funct3  in  3  RV32 load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 mem_rd_en  out  1  memory read strobe.
REQ-011 mem_addr  out  ADDR_W  word-aligned read address; bits [1:0] are always 00.
REQ-012 mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en; memory is little-endian.
REQ-013 resp_valid  out  1  result available.
REQ-014 resp_ready  in  1  consumer accepts the result.
REQ-015 resp_data  out  DATA_W  aligned, extended load result.
REQ-016 resp_err  out  1  illegal funct3, or crossing load with ALLOW_SPLIT=0.

Function
REQ-017 The FSM SHALL have states IDLE, RD_LO, RD_HI, LAST, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge with req_valid && req_ready, latching addr and funct3.
REQ-019 Crossing rule: LB/LBU never cross; LH/LHU cross iff addr[1:0]==11; LW crosses iff addr[1:0]!=00.
REQ-020 Illegal funct3, or a crossing load with ALLOW_SPLIT=0, SHALL go IDLE->RESP with resp_err=1, resp_data=0 and no mem_rd_en pulse.
REQ-021 RD_LO SHALL drive mem_rd_en=1 and mem_addr={addr[ADDR_W-1:2],00}; next state is RD_HI if the load crosses, else LAST.
REQ-022 RD_HI SHALL capture mem_rdata as the low word and drive mem_rd_en=1 with mem_addr = low word address + 4.
REQ-023 The word address SHALL wrap modulo 2^ADDR_W: low word address all-ones[ADDR_W-1:2] gives high word address 0.
REQ-024 LAST SHALL take the {high,low} (or the single word), select bytes starting at addr[1:0], zero- or sign-extend per funct3, register the result, and go to RESP.
REQ-025 Sign extension SHALL replicate bit 7 (LB) or bit 15 (LH); LBU/LHU SHALL zero-fill.
REQ-026 RESP SHALL hold resp_valid=1 with stable resp_data/resp_err until resp_ready=1, then return to IDLE.
REQ-027 Latency from the accept edge: resp_valid is asserted in the 3rd cycle (non-split), 4th cycle (split), or 1st cycle (error).
REQ-028 mem_rd_en SHALL be 0 in every state other than RD_LO and RD_HI; at most two reads per request.
REQ-029 No new request is accepted while resp_valid=1; back-to-back requests SHALL have at least one IDLE cycle.

Reset
REQ-030 While rst_n=0: state=IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0, latched registers=0.
REQ-031 Reset asserted mid-operation SHALL abort immediately with no response; the first request after release SHALL behave normally.

Structure
REQ-032 Package load_pkg SHALL hold the funct3 constants, the state enum and the crossing function.
REQ-033 Byte select plus extension SHALL be a combinational sub-module, load_extend, instanced once in LAST.

Verification
REQ-034 Memory preload for all scenarios: word 0x100=0x8899AABB, word 0x104=0x11223344.
REQ-035 LB at 0x101 -> one read of 0x100; resp_data=0xFFFFFFAA in cycle 3; resp_err=0.
REQ-036 LHU at 0x102 -> resp_data=0x00008899; LH at 0x102 -> 0xFFFF8899.
REQ-037 LW at 0x103 -> reads 0x100 then 0x104; resp_data=0x22334488 in cycle 4; LH at 0x103 -> 0x00004488.
REQ-038 resp_ready held low 3 cycles -> resp_valid and resp_data stable, req_ready=0; release -> IDLE.
REQ-039 funct3=011 -> resp_err=1, data 0, no read; with ALLOW_SPLIT=0, LW at 0x102 -> resp_err=1, no read.
REQ-040 rst_n low during RD_HI -> mem_rd_en drops the same cycle, no resp_valid; next LBU at 0x100 -> 0x000000BB.
